// File: rtl/gate_test_pkg.sv
// gate_test_pkg: shared state encodings and 2-input gate truth tables
package gate_test_pkg;
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] SAMPLE = 2'd2;
    localparam logic [1:0] FINISH = 2'd3;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_XNOR = 4'b1001;
endpackage

// File: rtl/settle_timer.sv
// settle_timer: loadable down-counter that stops at zero
module settle_timer #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         LOAD,
    input  logic [W-1:0] LOAD_VAL,
    output logic         ZERO
);
    logic [W-1:0] cnt;
    always_ff @(posedge CLK) begin
        if (RST)
            cnt <= '0;
        else if (LOAD)
            cnt <= LOAD_VAL;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end
    assign ZERO = cnt == '0;
endmodule

// File: rtl/gate_truth_sequencer.sv
// gate_truth_sequencer: walks A/B through all four vectors and checks X against a truth table
module gate_truth_sequencer
    import gate_test_pkg::*;
#(
    parameter logic [3:0] EXPECT     = TT_NAND,
    parameter int         SETTLE_CYC = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       X,
    output logic       A,
    output logic       B,
    output logic       BUSY,
    output logic       DONE,
    output logic       PASS,
    output logic [2:0] ERR_CNT,
    output logic [3:0] FAIL_VEC
);
    logic [1:0] state;
    logic [1:0] idx;
    logic       zero;
    logic       mis;
    logic       load;
    logic [3:0] fv_next;
    assign mis     = X != EXPECT[idx];
    assign fv_next = FAIL_VEC | (4'(mis) << idx);
    assign load    = (state == IDLE && START) || (state == SAMPLE && idx != 2'd3);
    assign BUSY    = state == SETTLE || state == SAMPLE;
    assign DONE    = state == FINISH;
    settle_timer #(.W(8)) u_timer (
        .CLK     (CLK),
        .RST     (RST),
        .LOAD    (load),
        .LOAD_VAL(8'(SETTLE_CYC - 1)),
        .ZERO    (zero)
    );
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            idx      <= '0;
            {B, A}   <= '0;
            ERR_CNT  <= '0;
            FAIL_VEC <= '0;
            PASS     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (START) begin
                    idx      <= '0;
                    {B, A}   <= '0;
                    ERR_CNT  <= '0;
                    FAIL_VEC <= '0;
                    PASS     <= 1'b0;
                    state    <= SETTLE;
                end
                SETTLE: if (zero) state <= SAMPLE;
                SAMPLE: begin
                    ERR_CNT  <= ERR_CNT + 3'(mis);
                    FAIL_VEC <= fv_next;
                    if (idx == 2'd3) begin
                        PASS  <= fv_next == '0;
                        state <= FINISH;
                    end else begin
                        idx    <= idx + 2'd1;
                        {B, A} <= idx + 2'd1;
                        state  <= SETTLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gate_truth_sequencer.sv
// tb_gate_truth_sequencer: scoreboard bench for the gate truth sequencer
module tb_gate_truth_sequencer;
    import gate_test_pkg::*;
    typedef struct packed {
        logic       pass;
        logic [2:0] err;
        logic [3:0] fv;
    } exp_t;
    logic clk = 0, rst = 1, start0 = 0, start1 = 0;
    logic [1:0] mode0 = 0, mode1 = 0;
    logic x0, x1, a0, b0, a1, b1, busy0, busy1, done0, done1, pass0, pass1;
    logic [2:0] err0, err1;
    logic [3:0] fv0, fv1;
    exp_t q[$];
    int vecs = 0, errs = 0;
    always #5 clk = ~clk;
    function automatic logic gate(input logic [1:0] m, input logic a, input logic b);
        return m == 0 ? ~(a & b) : m == 1 ? 1'b1 : m == 2 ? 1'b0 : (a & b);
    endfunction
    assign x0 = gate(mode0, a0, b0);
    assign x1 = gate(mode1, a1, b1);
    gate_truth_sequencer dut0 (
        .CLK(clk), .RST(rst), .START(start0), .X(x0), .A(a0), .B(b0), .BUSY(busy0),
        .DONE(done0), .PASS(pass0), .ERR_CNT(err0), .FAIL_VEC(fv0));
    gate_truth_sequencer #(.EXPECT(TT_AND), .SETTLE_CYC(1)) dut1 (
        .CLK(clk), .RST(rst), .START(start1), .X(x1), .A(a1), .B(b1), .BUSY(busy1),
        .DONE(done1), .PASS(pass1), .ERR_CNT(err1), .FAIL_VEC(fv1));
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    function automatic exp_t model(input logic [1:0] m, input logic [3:0] tt);
        exp_t e = '0;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] v = 2'(i);
            if (gate(m, v[0], v[1]) != tt[i]) begin
                e.fv[i] = 1'b1;
                e.err++;
            end
        end
        e.pass = e.fv == 0;
        return e;
    endfunction
    task automatic run_vec(input bit sel, input logic [1:0] m, input logic [3:0] tt, input int settle, input bit poke);
        int per = settle + 1;
        int last = 4 * per;
        exp_t e, got;
        logic [1:0] ab, ab_exp;
        logic bz, dn;
        if (sel) mode1 = m; else mode0 = m;
        q.push_back(model(m, tt));
        if (sel) start1 = 1; else start0 = 1;
        tick();
        start0 = 0;
        start1 = 0;
        for (int k = 0; k <= last + 1; k++) begin
            ab = sel ? {b1, a1} : {b0, a0};
            bz = sel ? busy1 : busy0;
            dn = sel ? done1 : done0;
            ab_exp = k < last ? 2'(k / per) : 2'd3;
            vecs++;
            if (ab !== ab_exp) begin errs++; $display("FAIL ab k=%0d got %b want %b", k, ab, ab_exp); end
            vecs++;
            if (bz !== (k < last)) begin errs++; $display("FAIL busy k=%0d got %b want %b", k, bz, k < last); end
            vecs++;
            if (dn !== (k == last)) begin errs++; $display("FAIL done k=%0d got %b want %b", k, dn, k == last); end
            if (k == last) begin
                vecs++;
                if (q.size() == 0) begin
                    errs++;
                    $display("FAIL scoreboard empty at done");
                end else begin
                    e = q.pop_front();
                    got = sel ? {pass1, err1, fv1} : {pass0, err0, fv0};
                    if (got !== e) begin
                        errs++;
                        $display("FAIL result pass/err/fv got %b/%0d/%b want %b/%0d/%b", got.pass, got.err, got.fv, e.pass, e.err, e.fv);
                    end
                end
            end
            if (poke) begin
                start0 = sel ? 1'b0 : (k == 3 || k == last);
                start1 = sel ? (k == 3 || k == last) : 1'b0;
            end
            if (k <= last) tick();
        end
        start0 = 0;
        start1 = 0;
    endtask
    task automatic test_reset();
        rst = 1;
        tick();
        tick();
        rst = 0;
        vecs++;
        if ({a0, b0, busy0, done0, pass0, err0, fv0} !== '0) begin
            errs++;
            $display("FAIL reset got a=%b b=%b busy=%b done=%b pass=%b err=%0d fv=%b want all 0", a0, b0, busy0, done0, pass0, err0, fv0);
        end
        vecs++;
        if ({a1, b1, busy1, done1, pass1, err1, fv1} !== '0) begin
            errs++;
            $display("FAIL reset1 got a=%b b=%b busy=%b done=%b want all 0", a1, b1, busy1, done1);
        end
    endtask
    task automatic test_nand();
        run_vec(0, 0, TT_NAND, 2, 0);
    endtask
    task automatic test_restart_ignored();
        run_vec(0, 0, TT_NAND, 2, 1);
        run_vec(0, 0, TT_NAND, 2, 0);
    endtask
    task automatic test_stuck_x();
        run_vec(0, 1, TT_NAND, 2, 0);
        run_vec(0, 2, TT_NAND, 2, 0);
    endtask
    task automatic test_mid_run_reset();
        bit saw_done = 0;
        start0 = 1;
        tick();
        start0 = 0;
        repeat (4) tick();
        rst = 1;
        tick();
        rst = 0;
        vecs++;
        if ({a0, b0, busy0, done0, pass0, err0, fv0} !== '0) begin
            errs++;
            $display("FAIL midreset got a=%b b=%b busy=%b done=%b pass=%b err=%0d fv=%b want all 0", a0, b0, busy0, done0, pass0, err0, fv0);
        end
        repeat (20) begin
            tick();
            if (done0 || busy0) saw_done = 1;
        end
        vecs++;
        if (saw_done !== 1'b0) begin errs++; $display("FAIL aborted_run got activity=%b want 0", saw_done); end
        run_vec(0, 0, TT_NAND, 2, 0);
    endtask
    task automatic test_and_config();
        run_vec(1, 3, TT_AND, 1, 0);
        run_vec(1, 0, TT_AND, 1, 0);
    endtask
    task automatic test_back_to_back();
        int d[3];
        int nd = 0;
        exp_t e;
        mode0 = 0;
        repeat (3) q.push_back(model(0, TT_NAND));
        start0 = 1;
        tick();
        for (int c = 0; c <= 44; c++) begin
            if (done0) begin
                vecs++;
                if (q.size() == 0) begin
                    errs++;
                    $display("FAIL b2b extra done at c=%0d", c);
                end else begin
                    e = q.pop_front();
                    if ({pass0, err0, fv0} !== e) begin
                        errs++;
                        $display("FAIL b2b result got %b/%0d/%b want %b/%0d/%b", pass0, err0, fv0, e.pass, e.err, e.fv);
                    end
                end
                if (nd < 3) d[nd] = c;
                nd++;
            end
            tick();
        end
        start0 = 0;
        vecs++;
        if (nd != 3) begin errs++; $display("FAIL b2b done_count got %0d want 3", nd); end
        else begin
            vecs++;
            if (d[0] != 12) begin errs++; $display("FAIL b2b first_done got %0d want 12", d[0]); end
            vecs++;
            if (d[1] - d[0] != 14 || d[2] - d[1] != 14) begin
                errs++;
                $display("FAIL b2b gap got %0d,%0d want 14,14", d[1] - d[0], d[2] - d[1]);
            end
        end
        q.delete();
        rst = 1;
        tick();
        rst = 0;
    endtask
    initial begin
        test_reset();
        test_nand();
        test_restart_ignored();
        test_stuck_x();
        test_mid_run_reset();
        test_and_config();
        test_back_to_back();
        vecs++;
        if (q.size() != 0) begin errs++; $display("FAIL scoreboard leftover got %0d want 0", q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/gate_truth_sequencer.md
Name: gate_truth_sequencer

Overview:
- Sequential stimulus-and-check stage for 2-input basic gates.
- Drives the gate's A/B inputs through all four combinations, in order (0,0), (1,0), (0,1), (1,1).
- Waits a programmable settle time per vector, samples the gate output X and compares it against an expected truth table.
- Reports pass/fail, an error count and a per-vector failure map; sits directly upstream/downstream of any nand_gate-style cell for on-chip self-test.

Parameters:
- EXPECT, 4'b0111, expected X per vector index idx (bit idx); idx0=(A0,B0), idx1=(A1,B0), idx2=(A0,B1), idx3=(A1,B1); default is NAND.
- SETTLE_CYC, 2, cycles A/B are held before X is sampled; legal range 1..255.

Ports:
- CLK  input  1  clock; all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- START  input  1  run request; sampled only in IDLE.
- X  input  1  output of gate under test.
- A  output  1  gate input A, registered; equals idx[0].
- B  output  1  gate input B, registered; equals idx[1].
- BUSY  output  1  high in SETTLE and SAMPLE states.
- DONE  output  1  one-cycle pulse, high in FINISH state.
- PASS  output  1  1 when last run had zero mismatches; held until next run starts.
- ERR_CNT  output  3  mismatch count of current/last run (0..4).
- FAIL_VEC  output  4  bit idx set when vector idx mismatched.

Behaviour:
- Interface: one clock CLK; reset RST is synchronous, active-high.
- Reset (RST=1 at an edge): state=IDLE, idx=0, A=0, B=0, counter=0, ERR_CNT=0, FAIL_VEC=0, PASS=0. BUSY=0 and DONE=0 follow from state.
- Reset has priority over START at any time, including mid-run. No DONE is produced for an aborted run.
- States: IDLE, SETTLE, SAMPLE, FINISH, encoded as 2-bit localparams.
- IDLE, START=1 at edge E0: idx<=0, A<=0, B<=0, cnt<=SETTLE_CYC-1, ERR_CNT<=0, FAIL_VEC<=0, PASS<=0, go to SETTLE.
- SETTLE: if cnt==0 go to SAMPLE, else cnt<=cnt-1. A and B are stable for the whole state.
- SAMPLE, comparison: if X != EXPECT[idx], set ERR_CNT<=ERR_CNT+1 and FAIL_VEC[idx]<=1.
- SAMPLE, idx<3: idx<=idx+1, A/B<=bits of idx+1, cnt reload, go to SETTLE.
- SAMPLE, idx==3: PASS<=(next FAIL_VEC==0), including the current compare; go to FINISH.
- FINISH: lasts exactly one cycle, then IDLE. A/B hold (1,1) until the next START.
- Timing: each vector occupies SETTLE_CYC+1 cycles.
- DONE is visible after edge 4*(SETTLE_CYC+1) counted from E0; with the default, after edge E12.
- PASS, ERR_CNT and FAIL_VEC are final and valid in the DONE cycle, and hold until the next START.
- START while BUSY or in FINISH: ignored. No restart and no extra DONE.
- START held high continuously: a new run starts at the first edge in IDLE after FINISH.
- X is sampled only at the SAMPLE edge; glitches on X during SETTLE have no effect.
- ERR_CNT cannot overflow: maximum is 4, and it is 3 bits wide.

Decomposition:
- Package gate_test_pkg:
  - state localparams IDLE/SETTLE/SAMPLE/FINISH;
  - truth-table constants TT_NAND=4'b0111, TT_AND=4'b1000, TT_OR=4'b1110, TT_NOR=4'b0001, TT_XOR=4'b0110, TT_XNOR=4'b1001.
- One natural sub-module: settle_timer, a loadable down-counter.
  - Inputs: LOAD, LOAD_VAL.
  - Output: ZERO.
  - Reused by later gate test stages.
- Everything else stays in gate_truth_sequencer.

Test Plan:
1. Default params, DUT = nand_gate, START pulse at E0 -> A/B sequence (0,0),(1,0),(0,1),(1,1), each held 3 cycles; DONE single pulse after E12; PASS=1, ERR_CNT=0, FAIL_VEC=4'b0000.
2. X tied to 1 -> DONE after E12; FAIL_VEC=4'b1000, ERR_CNT=1, PASS=0. Then X tied to 0, new START -> FAIL_VEC=4'b0111, ERR_CNT=3, PASS=0 (counts cleared at start).
3. START re-pulsed at E4 and during FINISH -> ignored; exactly one DONE after E12; next START in IDLE runs normally.
4. RST asserted at E5 mid-run -> next edge: A=B=0, BUSY=0, ERR_CNT=0, FAIL_VEC=0, PASS=0, no DONE. Fresh START -> normal completion, PASS=1.
5. SETTLE_CYC=1, EXPECT=TT_AND, DUT = AND gate -> DONE after E8, PASS=1. Same run with nand_gate as DUT -> FAIL_VEC=4'b1111, ERR_CNT=4.
6. START held high continuously -> back-to-back runs. DONE cycles are 14 cycles apart (13 run + 1 IDLE), default params; PASS never drops mid-report.
